// File: rtl/seg_msg_scroller.sv
// seg_msg_scroller: writable glyph message scrolled across a multiplexed common-cathode 7-seg display
module seg_msg_scroller #(
  parameter int NUM_DIGITS  = 4,
  parameter int MSG_LEN     = 8,
  parameter int STEP_DIV    = 3000000,
  parameter int REFRESH_DIV = 12000,
  parameter int CHAR_W      = 5,
  parameter int ADDR_W      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [CHAR_W-1:0]     wr_data,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  loop,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  busy,
  output logic                  done
);
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] pos_q, pos_d, pos_inc, rd_idx;
  logic [AW:0] rd_sum;
  logic [SW-1:0] step_q, step_d;
  logic [RW-1:0] ref_q;
  logic [DW-1:0] dig_q;
  logic [CHAR_W-1:0] msg_q [MSG_LEN];
  logic [6:0] seg_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic step_tc, ref_tc, wr_ok;
  function automatic logic [6:0] glyph(input logic [CHAR_W-1:0] c);
    case (32'(c))
      0:  glyph = 7'h7E;
      1:  glyph = 7'h30;
      2:  glyph = 7'h6D;
      3:  glyph = 7'h79;
      4:  glyph = 7'h33;
      5:  glyph = 7'h5B;
      6:  glyph = 7'h5F;
      7:  glyph = 7'h70;
      8:  glyph = 7'h7F;
      9:  glyph = 7'h7B;
      10: glyph = 7'h77;
      11: glyph = 7'h1F;
      12: glyph = 7'h4E;
      13: glyph = 7'h3D;
      14: glyph = 7'h4F;
      15: glyph = 7'h47;
      17: glyph = 7'h5B;
      18: glyph = 7'h3E;
      19: glyph = 7'h3D;
      20: glyph = 7'h30;
      21: glyph = 7'h67;
      22: glyph = 7'h0F;
      23: glyph = 7'h37;
      24: glyph = 7'h0E;
      25: glyph = 7'h01;
      default: glyph = 7'h00;
    endcase
  endfunction
  assign step_tc = step_q == SW'(STEP_DIV - 1);
  assign ref_tc  = ref_q == RW'(REFRESH_DIV - 1);
  assign wr_ok   = wr_en && (32'(wr_addr) < MSG_LEN);
  assign pos_inc = (pos_q == AW'(MSG_LEN - 1)) ? '0 : pos_q + 1'b1;
  // window character for the lit digit, wrapped modulo MSG_LEN
  assign rd_sum  = {1'b0, pos_q} + (AW+1)'(dig_q);
  assign rd_idx  = AW'((rd_sum >= (AW+1)'(MSG_LEN)) ? rd_sum - (AW+1)'(MSG_LEN) : rd_sum);
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    step_d  = step_q;
    if (start) begin
      state_d = pause ? HOLD : RUN;
      pos_d   = '0;
      step_d  = '0;
    end else if (state_q == RUN) begin
      if (pause) state_d = HOLD;
      else if (!step_tc) step_d = step_q + 1'b1;
      else begin
        step_d = '0;
        if (!loop && pos_q == AW'(MSG_LEN - NUM_DIGITS)) state_d = DONE;
        else pos_d = pos_inc;
      end
    end else if (state_q == HOLD && !pause) state_d = RUN;
  end
  always_comb begin
    busy    = (state_q == RUN) || (state_q == HOLD);
    done    = state_q == DONE;
    seg_out = seg_q;
    dig_sel = sel_q;
  end
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      ref_q <= '0;
      dig_q <= '0;
    end else begin
      ref_q <= ref_tc ? '0 : ref_q + 1'b1;
      if (ref_tc) dig_q <= (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;
    end
  end
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= CHAR_W'(16);
    end else if (wr_ok) begin
      msg_q[wr_addr[AW-1:0]] <= wr_data;
    end
  end
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      seg_q <= 7'h00;
      sel_q <= '1;
    end else begin
      seg_q <= (state_q == IDLE) ? 7'h00 : glyph(msg_q[rd_idx]);
      sel_q <= (state_q == IDLE) ? '1 : ~(NUM_DIGITS'(1) << dig_q);
    end
  end
endmodule

// File: tb/tb_seg_msg_scroller.sv
// tb_seg_msg_scroller: cycle model feeds an expectation queue, checked against the scroller each clock
module tb_seg_msg_scroller;
  localparam int N = 2, M = 4, S = 4, R = 2, CW = 5, AW = 3;
  localparam logic [6:0] GL [32] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47,
    7'h00, 7'h5B, 7'h3E, 7'h3D, 7'h30, 7'h67, 7'h0F, 7'h37,
    7'h0E, 7'h01, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  typedef struct packed {
    logic [6:0]   seg;
    logic [N-1:0] sel;
    logic         busy;
    logic         done;
  } exp_t;
  logic clk1 = 0, rst_n = 0, wr_en = 0, start = 0, pause = 0, loop = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic [6:0] seg_out;
  logic [N-1:0] dig_sel;
  logic busy, done;
  int checks = 0, failures = 0;
  int m_st, m_pos, m_step, m_ref, m_dig;
  int m_msg [M];
  exp_t q [$];
  logic [6:0] last0 = '0, last1 = '0;
  logic saw_wrap = 0, saw_dash = 0, saw_any = 0;

  always #5 clk1 = ~clk1;

  seg_msg_scroller #(
    .NUM_DIGITS(N), .MSG_LEN(M), .STEP_DIV(S), .REFRESH_DIV(R), .CHAR_W(CW), .ADDR_W(AW)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .pause(pause), .loop(loop), .seg_out(seg_out), .dig_sel(dig_sel),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    exp_t e;
    int ns;
    if (!rst_n) begin
      e.seg = 7'h00; e.sel = '1; e.busy = 1'b0; e.done = 1'b0;
      m_st = 0; m_pos = 0; m_step = 0; m_ref = 0; m_dig = 0;
      foreach (m_msg[i]) m_msg[i] = 16;
    end else begin
      e.seg = (m_st == 0) ? 7'h00 : GL[m_msg[(m_pos + m_dig) % M]];
      e.sel = (m_st == 0) ? '1 : ~(N'(1) << m_dig);
      ns = m_st;
      if (start) begin
        ns = pause ? 2 : 1; m_pos = 0; m_step = 0;
      end else if (m_st == 1 && pause) ns = 2;
      else if (m_st == 1) begin
        if (m_step < S - 1) m_step++;
        else begin
          m_step = 0;
          if (loop) m_pos = (m_pos + 1) % M;
          else if (m_pos == M - N) ns = 3;
          else m_pos++;
        end
      end else if (m_st == 2 && !pause) ns = 1;
      m_st = ns;
      e.busy = (ns == 1 || ns == 2);
      e.done = (ns == 3);
      if (wr_en && wr_addr < M) m_msg[wr_addr] = int'(wr_data);
      if (m_ref == R - 1) begin m_ref = 0; m_dig = (m_dig + 1) % N; end
      else m_ref++;
    end
    q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model();
    @(posedge clk1);
    #1;
    e = q.pop_front();
    chk("seg_out", 32'(seg_out), 32'(e.seg));
    chk("dig_sel", 32'(dig_sel), 32'(e.sel));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    if (dig_sel == 2'b10) last0 = seg_out;
    if (dig_sel == 2'b01) last1 = seg_out;
    if (dig_sel == 2'b01 && seg_out == 7'h5B) saw_wrap = 1;
    if (seg_out == 7'h01) saw_dash = 1;
    if (seg_out != 7'h00) saw_any = 1;
  endtask

  initial begin
    rst_n = 0;
    tick(); tick();
    chk("rst_seg", 32'(seg_out), 0);
    chk("rst_sel", 32'(dig_sel), 3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1;
    tick();
    for (int i = 0; i < M; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = CW'(17 + i);
      tick();
    end
    wr_en = 0;
    loop = 1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("loop_d0_S", 32'(last0), 32'h5B);
    chk("loop_d1_U", 32'(last1), 32'h3E);
    saw_wrap = 0;
    for (int i = 0; i < 16; i++) tick();
    chk("loop_wrap", 32'(saw_wrap), 1);
    loop = 0; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 16; i++) tick();
    chk("oneshot_done", 32'(done), 1);
    chk("oneshot_busy", 32'(busy), 0);
    last0 = '0; last1 = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("oneshot_d0", 32'(last0), 32'h3D);
    chk("oneshot_d1", 32'(last1), 32'h30);
    loop = 1; start = 1;
    tick();
    start = 0;
    tick();
    chk("restart_busy", 32'(busy), 1);
    pause = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("hold_busy", 32'(busy), 1);
    chk("hold_done", 32'(done), 0);
    pause = 0;
    for (int i = 0; i < 8; i++) tick();
    saw_dash = 0;
    wr_en = 1; wr_addr = 3'd5; wr_data = CW'(25);
    tick();
    wr_en = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("oob_write_ignored", 32'(saw_dash), 0);
    wr_en = 1; wr_addr = 3'd1; wr_data = CW'(25);
    tick();
    wr_en = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("live_write_dash", 32'(saw_dash), 1);
    for (int i = 0; i < 40 && m_pos != 2; i++) tick();
    rst_n = 0;
    tick();
    chk("midrun_rst_seg", 32'(seg_out), 0);
    chk("midrun_rst_sel", 32'(dig_sel), 3);
    chk("midrun_rst_busy", 32'(busy), 0);
    rst_n = 1; start = 1;
    tick();
    start = 0;
    saw_any = 0;
    for (int i = 0; i < 16; i++) tick();
    chk("cleared_blank", 32'(saw_any), 0);
    chk("cleared_busy", 32'(busy), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
